// File: rtl/eu_iqueue.sv
// Per-EU instruction queue: circular buffer feeding operand pre-population,
// plus a one-entry issue stage that holds instruction and resolved operands for the ALU.
package eu_iqueue_pkg;
  localparam int EU_IDX_W = 2;
  localparam int DATA_W   = 16;

  typedef logic [DATA_W-1:0] type_exec_unit_data;

  typedef struct packed {
    logic [EU_IDX_W-1:0]        eu_idx;
    logic [DATA_W-EU_IDX_W-1:0] reg_idx;
  } type_op_addr;

  typedef struct packed {
    type_exec_unit_data data;
  } type_op_imm;

  typedef union packed {
    type_op_addr as_addr;
    type_op_imm  as_imm;
  } type_operand;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        op0_isreg;
    logic        op1_isreg;
    type_operand op0;
    type_operand op1;
  } type_iqueue_entry;
endpackage

module eu_iqueue
  import eu_iqueue_pkg::*;
#(
  parameter  int EU_IDX = 0,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq_valid_i,
  output logic               enq_ready_o,
  input  type_iqueue_entry   enq_instr_i,
  input  logic               flush_i,
  output type_iqueue_entry   current_instr_o,
  output logic               head_valid_o,
  output logic               op0_isreg_o,
  output logic               op0_isforeign_o,
  output logic               op1_isreg_o,
  output logic               op1_isforeign_o,
  input  type_exec_unit_data op0_data_i,
  input  logic               op0_success_i,
  input  type_exec_unit_data op1_data_i,
  input  logic               op1_success_i,
  input  logic               alu_ready_i,
  output logic               issue_valid_o,
  output type_iqueue_entry   issue_instr_o,
  output type_exec_unit_data issue_op0_o,
  output type_exec_unit_data issue_op1_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [EU_IDX_W-1:0] EU_IDX_L = EU_IDX_W'(EU_IDX);

  type_iqueue_entry   mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               issue_valid_q, issue_valid_d;
  type_iqueue_entry   issue_instr_q, issue_instr_d;
  type_exec_unit_data issue_op0_q, issue_op0_d;
  type_exec_unit_data issue_op1_q, issue_op1_d;

  logic             head_valid;
  logic             enq_fire;
  logic             issue_free;
  logic             pop;
  type_iqueue_entry head;

  assign head_valid  = (count_q != '0);
  assign enq_ready_o = (count_q != CNT_W'(DEPTH));
  assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;
  assign head        = head_valid ? mem_q[rd_ptr_q] : '0;
  assign issue_free  = ~issue_valid_q | alu_ready_i;
  assign pop         = head_valid & op0_success_i & op1_success_i & issue_free & ~flush_i;

  assign current_instr_o = head;
  assign head_valid_o    = head_valid;
  assign op0_isreg_o     = head_valid & head.op0_isreg;
  assign op1_isreg_o     = head_valid & head.op1_isreg;
  assign op0_isforeign_o = op0_isreg_o & (head.op0.as_addr.eu_idx != EU_IDX_L);
  assign op1_isforeign_o = op1_isreg_o & (head.op1.as_addr.eu_idx != EU_IDX_L);

  assign issue_valid_o = issue_valid_q;
  assign issue_instr_o = issue_instr_q;
  assign issue_op0_o   = issue_op0_q;
  assign issue_op1_o   = issue_op1_q;
  assign count_o       = count_q;

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    issue_valid_d = issue_valid_q;
    issue_instr_d = issue_instr_q;
    issue_op0_d   = issue_op0_q;
    issue_op1_d   = issue_op1_q;
    if (flush_i) begin
      // Issue data regs keep stale values; only the valid bit is cleared.
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      issue_valid_d = 1'b0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        issue_valid_d = 1'b1;
        issue_instr_d = head;
        issue_op0_d   = op0_data_i;
        issue_op1_d   = op1_data_i;
      end else if (issue_valid_q & alu_ready_i) begin
        issue_valid_d = 1'b0;
      end
      case ({enq_fire, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      issue_op0_q   <= '0;
      issue_op1_q   <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      issue_op0_q   <= issue_op0_d;
      issue_op1_q   <= issue_op1_d;
    end
  end

  // Storage is not reset; empty slots are masked by head_valid.
  always_ff @(posedge clk) begin
    if (reset_n && enq_fire) mem_q[wr_ptr_q] <= enq_instr_i;
  end

endmodule
